// File: rtl/serializer_feed_if.sv
// serializer_feed_if: word handshake into the serializer and the framed serial stream out of it.
// master = upstream/observer side, slave = serializer side.
interface serializer_feed_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             last;
  logic             busy;

  modport master (
    output din, load_valid,
    input  load_ready, sout, sout_valid, last, busy
  );

  modport slave (
    input  din, load_valid,
    output load_ready, sout, sout_valid, last, busy
  );
endinterface

// File: rtl/serializer_feed.sv
// serializer_feed: loads a WIDTH-bit word on a valid/ready handshake and presents it one bit per clk.
// Define SERIALIZER_PARITY_EN to append one parity cycle to every frame.
module serializer_feed #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit IDLE_LVL   = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input logic              clk,
  input logic              clear,
  serializer_feed_if.slave bus
);
  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
`ifdef SERIALIZER_PARITY_EN
    , PARITY = 2'd2
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] bit_idx;
  logic             accept;

  // The final frame cycle also accepts, so consecutive words chain with no gap.
  assign bus.load_ready = (state_q == IDLE) || last_q;
  assign accept         = bus.load_valid && bus.load_ready;

  assign bus.sout       = sout_q;
  assign bus.sout_valid = sout_valid_q;
  assign bus.last       = last_q;
  assign bus.busy       = (state_q != IDLE);

  // NOTE: non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shadow_q     <= '0;
      sout_q       <= IDLE_LVL;
      sout_valid_q <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      last_q       <= last_d;
    end
  end

  always_comb begin
    // NOTE: hold-value defaults first, so no path through this block infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = SHIFT;
          cnt_d    = '0;
          shadow_d = bus.din;
        end
      end
      SHIFT: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
`ifdef SERIALIZER_PARITY_EN
        end else begin
          state_d = PARITY;
        end
      end
      PARITY: begin
        if (accept) begin
          state_d  = SHIFT;
          cnt_d    = '0;
          shadow_d = bus.din;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
`else
        end else if (accept) begin
          cnt_d    = '0;
          shadow_d = bus.din;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    bit_idx      = MSB_FIRST ? (CNT_LAST - cnt_d) : cnt_d;
    sout_d       = IDLE_LVL;
    sout_valid_d = 1'b0;
    last_d       = 1'b0;
    unique case (state_d)
      SHIFT: begin
        sout_d       = shadow_d[bit_idx];
        sout_valid_d = 1'b1;
`ifndef SERIALIZER_PARITY_EN
        last_d       = (cnt_d == CNT_LAST);
`endif
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        sout_d       = (^shadow_d) ^ PARITY_ODD;
        sout_valid_d = 1'b1;
        last_d       = 1'b1;
      end
`endif
      default: begin
        sout_d = IDLE_LVL;
      end
    endcase
  end
endmodule

// File: tb/tb_serializer_feed.sv
// tb_serializer_feed: LSB-first and MSB-first instances driven in lockstep, checked against
// directed vector tables and a queue-of-bits reference model.
module tb_serializer_feed;
  localparam int WIDTH      = 8;
  localparam bit IDLE_LVL   = 1'b0;
  localparam bit PARITY_ODD = 1'b0;
`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             clear;
  logic [WIDTH-1:0] din;
  logic             load_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serializer_feed_if #(.WIDTH(WIDTH)) if_lsb ();
  serializer_feed_if #(.WIDTH(WIDTH)) if_msb ();

  assign if_lsb.din        = din;
  assign if_lsb.load_valid = load_valid;
  assign if_msb.din        = din;
  assign if_msb.load_valid = load_valid;

  serializer_feed #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .IDLE_LVL(IDLE_LVL), .PARITY_ODD(PARITY_ODD))
    dut_lsb (.clk(clk), .clear(clear), .bus(if_lsb.slave));

  serializer_feed #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .IDLE_LVL(IDLE_LVL), .PARITY_ODD(PARITY_ODD))
    dut_msb (.clk(clk), .clear(clear), .bus(if_msb.slave));

  // Reference model: each queue holds the bits still to appear on sout; element 0 is on sout now.
  bit q_lsb[$];
  bit q_msb[$];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge();
    bit accept;
    accept = load_valid && (q_lsb.size() <= 1);
    if (q_lsb.size() > 0) begin
      void'(q_lsb.pop_front());
      void'(q_msb.pop_front());
    end
    if (accept) begin
      for (int k = 0; k < WIDTH; k++) begin
        q_lsb.push_back(din[k]);
        q_msb.push_back(din[WIDTH-1-k]);
      end
`ifdef SERIALIZER_PARITY_EN
      q_lsb.push_back((^din) ^ PARITY_ODD);
      q_msb.push_back((^din) ^ PARITY_ODD);
`endif
    end
  endtask

  task automatic check_dut(input string tag, input logic sout, input logic sv, input logic lst,
                           input logic busy, input logic rdy, input bit q[$]);
    int n;
    n = q.size();
    check({tag, " sout"},       sout, (n > 0) ? q[0] : IDLE_LVL);
    check({tag, " sout_valid"}, sv,   n > 0);
    check({tag, " last"},       lst,  n == 1);
    check({tag, " busy"},       busy, n > 0);
    check({tag, " load_ready"}, rdy,  n <= 1);
  endtask

  task automatic check_both(input string tag);
    check_dut({tag, " lsb"}, if_lsb.sout, if_lsb.sout_valid, if_lsb.last, if_lsb.busy,
              if_lsb.load_ready, q_lsb);
    check_dut({tag, " msb"}, if_msb.sout, if_msb.sout_valid, if_msb.last, if_msb.busy,
              if_msb.load_ready, q_msb);
  endtask

  // Inputs are changed at the negedge; one step = one posedge, then a check at the next negedge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_both(tag);
  endtask

  // Called at a negedge: clear pulses low strictly between clock edges.
  task automatic pulse_clear(input string tag);
    #2 clear = 1'b0;
    q_lsb.delete();
    q_msb.delete();
    #1 check_both(tag);
    #1 clear = 1'b1;
  endtask

  typedef struct {
    bit             lv;
    logic [WIDTH-1:0] d;
    bit             e_lsb;
    bit             e_msb;
    bit             e_valid;
    bit             e_last;
    bit             e_ready;
  } vec_t;

  vec_t tbl[$];
  int   n_valid;
  int   n_last;
  int   last_pos0;
  int   last_pos1;

  initial begin
    // 8'h96 = 1001_0110: LSB-first 0,1,1,0,1,0,0,1 ; MSB-first 1,0,0,1,0,1,1,0
    tbl.push_back('{1'b1, 8'h96, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
`ifdef SERIALIZER_PARITY_EN
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
`else
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
`endif

    clear      = 1'b0;
    din        = '0;
    load_valid = 1'b0;
    @(negedge clk);
    check_both("reset");
    clear = 1'b1;

    // Abort a frame with an asynchronous clear, then serialize normally.
    din        = 8'h96;
    load_valid = 1'b1;
    step("pre-abort");
    load_valid = 1'b0;
    repeat (3) step("pre-abort");
    pulse_clear("abort");
    step("post-abort");

    for (int i = 0; i < tbl.size(); i++) begin
      din        = tbl[i].d;
      load_valid = tbl[i].lv;
      step("vec");
      check($sformatf("vec%0d lsb sout", i),   if_lsb.sout,       tbl[i].e_lsb);
      check($sformatf("vec%0d msb sout", i),   if_msb.sout,       tbl[i].e_msb);
      check($sformatf("vec%0d sout_valid", i), if_lsb.sout_valid, tbl[i].e_valid);
      check($sformatf("vec%0d last", i),       if_msb.last,       tbl[i].e_last);
      check($sformatf("vec%0d load_ready", i), if_lsb.load_ready, tbl[i].e_ready);
    end

    // Back-to-back: 8'h96 then 8'h0F with load_valid held high.
    n_valid   = 0;
    n_last    = 0;
    last_pos0 = -1;
    last_pos1 = -1;
    for (int i = 0; i <= 2 * FRAME; i++) begin
      din        = (i == 0) ? 8'h96 : 8'h0F;
      load_valid = (i <= FRAME);
      step("b2b");
      if (if_lsb.sout_valid) n_valid++;
      if (if_lsb.last) begin
        if (n_last == 0) last_pos0 = i;
        else             last_pos1 = i;
        n_last++;
      end
    end
    load_valid = 1'b0;
    check_int("b2b valid cycles", n_valid, 2 * FRAME);
    check_int("b2b last count", n_last, 2);
    check_int("b2b first last", last_pos0, FRAME - 1);
    check_int("b2b second last", last_pos1, 2 * FRAME - 1);

    // Mid-frame load attempt at bit 3 must be ignored.
    din        = 8'h96;
    load_valid = 1'b1;
    step("mid");
    load_valid = 1'b0;
    repeat (3) step("mid");
    check("mid load_ready at bit3", if_lsb.load_ready, 1'b0);
    din        = 8'hFF;
    load_valid = 1'b1;
    step("mid");
    load_valid = 1'b0;
    repeat (FRAME) step("mid");

`ifdef SERIALIZER_PARITY_EN
    // 8'h97 has five ones: even parity bit is 1.
    din        = 8'h97;
    load_valid = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      step("par97");
      load_valid = 1'b0;
    end
    check("par97 parity bit", if_lsb.sout, 1'b1);
    check("par97 last", if_msb.last, 1'b1);
    step("par97");
`endif

    // Random traffic with occasional asynchronous clears.
    for (int i = 0; i < 600; i++) begin
      din        = WIDTH'($urandom);
      load_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 79) == 0) pulse_clear("rand clear");
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
